// File: rtl/gpu_rect_raster.sv
// Per-pixel rect rasteriser: highest-index covering rect wins, double-buffered rect banks swapped at frame start.
// Optional colour-key transparency enabled by defining GPU_RASTER_TRANSPARENCY_EN.
module gpu_rect_raster #(
  parameter int          COORD_WIDTH       = 16,
  parameter int          RECT_COUNT        = 64,
  parameter int          RECT_COUNT_WIDTH  = 6,
  parameter int          COLOR_WIDTH       = 16,
  parameter logic [15:0] DEFAULT_COLOR     = 16'h0,
  parameter logic [15:0] TRANSPARENT_COLOR = 16'hF81F
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   copy_start,
  input  logic [15:0]            mem_din,
  input  logic                   mem_valid,
  input  logic                   frame_start,
  input  logic                   hsync,
  input  logic [COORD_WIDTH-1:0] x_coord,
  input  logic [COORD_WIDTH-1:0] y_coord,
  output logic                   loading,
  output logic                   swap_pending,
  output logic [COLOR_WIDTH-1:0] color
);

`ifdef GPU_RASTER_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif
  localparam logic [COLOR_WIDTH-1:0] KEY_COLOR = COLOR_WIDTH'(TRANSPARENT_COLOR);
  localparam logic [COLOR_WIDTH-1:0] BG_COLOR  = COLOR_WIDTH'(DEFAULT_COLOR);

  // state | meaning
  // IDLE  | no set being received
  // LOAD  | receiving rect words into the shadow bank
  // READY | complete set in shadow bank, waiting for frame_start
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t                      state, state_next;
  logic [2:0]                  field;
  logic [RECT_COUNT_WIDTH-1:0] rect_idx;
  logic                        last_word;
  logic                        swap;
  logic                        bank_sel;
  logic                        shadow_sel;
  logic                        active_valid;
  logic [COORD_WIDTH-1:0]      coord_word;
  logic [COORD_WIDTH-1:0]      y_next;

  logic [COORD_WIDTH-1:0] left_q   [2][RECT_COUNT];
  logic [COORD_WIDTH-1:0] top_q    [2][RECT_COUNT];
  logic [COORD_WIDTH-1:0] right_q  [2][RECT_COUNT];
  logic [COORD_WIDTH-1:0] bottom_q [2][RECT_COUNT];
  logic [COLOR_WIDTH-1:0] color_q  [2][RECT_COUNT];

  logic [RECT_COUNT-1:0]  row_mask, row_hit, x_hit, opaque, hit;
  logic                   hit_bank;
  logic [COLOR_WIDTH-1:0] sel_color;

  assign last_word    = (state == LOAD) && mem_valid && (field == 3'd4) &&
                        (rect_idx == RECT_COUNT_WIDTH'(RECT_COUNT - 1));
  assign swap         = (state == READY) && frame_start;
  assign shadow_sel   = ~bank_sel;
  assign coord_word   = COORD_WIDTH'(mem_din);
  assign y_next       = y_coord + COORD_WIDTH'(1);
  assign loading      = (state == LOAD);
  assign swap_pending = (state == READY);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // frame_start beats copy_start in READY; a restart needs copy_start reasserted
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (copy_start) state_next = LOAD;
      LOAD:    if (last_word) state_next = READY;
      READY: begin
        if (frame_start)     state_next = IDLE;
        else if (copy_start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state != LOAD) begin
      field    <= 3'd0;
      rect_idx <= '0;
    end else if (mem_valid && !last_word) begin
      if (field == 3'd4) begin
        field    <= 3'd0;
        rect_idx <= rect_idx + RECT_COUNT_WIDTH'(1);
      end else begin
        field <= field + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == LOAD && mem_valid) begin
      case (field)
        3'd0:    left_q[shadow_sel][rect_idx]   <= coord_word;
        3'd1:    top_q[shadow_sel][rect_idx]    <= coord_word;
        3'd2:    right_q[shadow_sel][rect_idx]  <= coord_word;
        3'd3:    bottom_q[shadow_sel][rect_idx] <= coord_word;
        default: color_q[shadow_sel][rect_idx]  <= mem_din[COLOR_WIDTH-1:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_sel     <= 1'b0;
      active_valid <= 1'b0;
    end else if (swap) begin
      bank_sel     <= ~bank_sel;
      active_valid <= 1'b1;
    end
  end

  always_comb begin
    row_hit = '0;
    x_hit   = '0;
    opaque  = '0;
    for (int i = 0; i < RECT_COUNT; i++) begin
      row_hit[i] = (top_q[bank_sel][i] <= y_next) && (y_next < bottom_q[bank_sel][i]);
      x_hit[i]   = (left_q[bank_sel][i] <= x_coord) && (x_coord < right_q[bank_sel][i]);
      opaque[i]  = !(KEY_EN && color_q[bank_sel][i] == KEY_COLOR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      row_mask <= '0;
    else if (hsync) row_mask <= row_hit;
  end

  // bank index travels with the hits so a swap never mixes banks within one pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      hit      <= '0;
      hit_bank <= 1'b0;
    end else begin
      hit      <= active_valid ? (x_hit & row_mask & opaque) : '0;
      hit_bank <= bank_sel;
    end
  end

  always_comb begin
    sel_color = BG_COLOR;
    for (int i = 0; i < RECT_COUNT; i++) begin
      if (hit[i]) sel_color = color_q[hit_bank][i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) color <= BG_COLOR;
    else       color <= sel_color;
  end

endmodule

// File: tb/tb_gpu_rect_raster.sv
// Self-checking bench for gpu_rect_raster: directed vector table, load/swap corner sequences, random sets vs a rect-list model.
module tb_gpu_rect_raster;
  localparam int          N   = 64;
  localparam logic [15:0] DEF = 16'h0000;
  localparam logic [15:0] KEY = 16'hF81F;
`ifdef GPU_RASTER_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, copy_start, mem_valid, frame_start, hsync;
  logic [15:0] mem_din, x_coord, y_coord;
  logic        loading, swap_pending;
  logic [15:0] color;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpu_rect_raster dut (
    .clk(clk), .reset(reset), .copy_start(copy_start), .mem_din(mem_din),
    .mem_valid(mem_valid), .frame_start(frame_start), .hsync(hsync),
    .x_coord(x_coord), .y_coord(y_coord), .loading(loading),
    .swap_pending(swap_pending), .color(color)
  );

  typedef struct packed {logic [15:0] l, t, r, b, c;} rect_t;
  typedef struct packed {logic [15:0] y, x, expv;} vec_t;

  rect_t       set_next [N];
  rect_t       pend     [N];
  rect_t       act      [N];
  bit          act_valid, pend_valid;
  logic [15:0] cur_row;
  vec_t        vecs [14];
  logic [15:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic logic [15:0] model_pix(input logic [15:0] x, input logic [15:0] row);
    if (!act_valid) return DEF;
    for (int i = N - 1; i >= 0; i--) begin
      if (x >= act[i].l && x < act[i].r && row >= act[i].t && row < act[i].b &&
          !(TRANSP && act[i].c == KEY))
        return act[i].c;
    end
    return DEF;
  endfunction

  function automatic logic [15:0] word_of(input int w);
    rect_t r;
    r = set_next[w / 5];
    case (w % 5)
      0:       return r.l;
      1:       return r.t;
      2:       return r.r;
      3:       return r.b;
      default: return r.c;
    endcase
  endfunction

  task automatic start_load();
    copy_start = 1'b1;
    tick();
    copy_start = 1'b0;
  endtask

  task automatic feed(input bit gaps, input bit poke);
    for (int w = 0; w < 5 * N; w++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        mem_valid = 1'b0;
        mem_din   = 16'hDEAD;
        tick();
      end
      mem_valid  = 1'b1;
      mem_din    = word_of(w);
      copy_start = poke && (w == 50);
      tick();
    end
    mem_valid  = 1'b0;
    copy_start = 1'b0;
    pend       = set_next;
    pend_valid = 1'b1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (pend_valid) begin
      act        = pend;
      act_valid  = 1'b1;
      pend_valid = 1'b0;
    end
  endtask

  task automatic start_line(input logic [15:0] y);
    y_coord = y - 16'd1;
    hsync   = 1'b1;
    tick();
    hsync   = 1'b0;
    cur_row = y;
  endtask

  task automatic pixel(input string name, input logic [15:0] x, input logic [15:0] want);
    x_coord = x;
    tick();
    tick();
    check(name, color, want);
  endtask

  task automatic spec_set();
    for (int i = 0; i < N; i++) set_next[i] = '0;
    set_next[0] = '{16'd0, 16'd0, 16'd10, 16'd10, 16'h1111};
    set_next[1] = '{16'd5, 16'd5, 16'd20, 16'd20, 16'h2222};
  endtask

  task automatic random_set();
    for (int i = 0; i < N; i++) begin
      set_next[i].l = 16'($urandom_range(0, 63));
      set_next[i].t = 16'($urandom_range(0, 63));
      set_next[i].r = 16'($urandom_range(0, 70));
      set_next[i].b = 16'($urandom_range(0, 70));
      set_next[i].c = 16'($urandom);
    end
  endtask

  task automatic stream_line(input logic [15:0] y);
    start_line(y);
    for (int k = 0; k < 41; k++) begin
      if (k < 40) begin
        x_coord = 16'($urandom_range(0, 72));
        exp_q.push_back(model_pix(x_coord, cur_row));
      end
      tick();
      if (k >= 1) check("stream_pixel", color, exp_q.pop_front());
    end
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{16'd0,  16'd3,  16'h1111};
    vecs[1]  = '{16'd0,  16'd12, DEF};
    vecs[2]  = '{16'd6,  16'd7,  16'h2222};
    vecs[3]  = '{16'd6,  16'd3,  16'h1111};
    vecs[4]  = '{16'd6,  16'd10, 16'h2222};
    vecs[5]  = '{16'd6,  16'd20, DEF};
    vecs[6]  = '{16'd6,  16'd19, 16'h2222};
    vecs[7]  = '{16'd6,  16'd4,  16'h1111};
    vecs[8]  = '{16'd6,  16'd27, DEF};
    vecs[9]  = '{16'd6,  16'd40, DEF};
    vecs[10] = '{16'd6,  16'd55, DEF};
    vecs[11] = '{16'd4,  16'd7,  16'h1111};
    vecs[12] = '{16'd19, 16'd19, 16'h2222};
    vecs[13] = '{16'd20, 16'd7,  DEF};

    reset = 1'b1; copy_start = 1'b0; mem_din = '0; mem_valid = 1'b0;
    frame_start = 1'b0; hsync = 1'b0; x_coord = '0; y_coord = '0;
    act_valid = 1'b0; pend_valid = 1'b0; cur_row = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset_loading", 16'(loading), 16'd0);
    check("reset_swap_pending", 16'(swap_pending), 16'd0);
    check("reset_color", color, DEF);

    // no set committed yet: background everywhere
    spec_set();
    start_load();
    feed(1'b0, 1'b0);
    check("pending_after_load", 16'(swap_pending), 16'd1);
    start_line(16'd6);
    pixel("inactive_bank", 16'd7, DEF);

    // spec set plus degenerate rects (right<=left, zero width, bottom<top)
    set_next[2] = '{16'd30, 16'd0,  16'd25, 16'd10, 16'h3333};
    set_next[3] = '{16'd40, 16'd0,  16'd40, 16'd10, 16'h4444};
    set_next[4] = '{16'd50, 16'd10, 16'd60, 16'd5,  16'h5555};
    start_load();
    feed(1'b0, 1'b0);
    frame();
    check("swap_clears_pending", 16'(swap_pending), 16'd0);
    for (int v = 0; v < 14; v++) begin
      if (v == 0 || vecs[v].y != vecs[v-1].y) start_line(vecs[v].y);
      pixel($sformatf("vec%0d", v), vecs[v].x, vecs[v].expv);
    end
    start_line(16'd6);
    y_coord = 16'd30;
    pixel("row_mask_held", 16'd7, 16'h2222);

    // set B waits in shadow bank until frame_start
    for (int i = 0; i < N; i++) set_next[i] = '0;
    set_next[5] = '{16'd0, 16'd0, 16'd100, 16'd100, 16'h5555};
    start_load();
    feed(1'b1, 1'b1);
    check("b_pending", 16'(swap_pending), 16'd1);
    start_line(16'd6);
    pixel("still_set_a", 16'd7, 16'h2222);
    frame();
    start_line(16'd6);
    pixel("set_b_live", 16'd7, 16'h5555);

    // mem_valid toggling every clk: loading high for 2*5*N-1 clk
    random_set();
    start_load();
    cnt = 0;
    for (int k = 0; k < 2000 && loading; k++) begin
      mem_valid = (k % 2 == 0);
      mem_din   = (k % 2 == 0) ? word_of(k / 2) : 16'hBEEF;
      cnt++;
      tick();
    end
    mem_valid = 1'b0;
    pend = set_next; pend_valid = 1'b1;
    check("toggle_load_len", 16'(cnt), 16'(2 * 5 * N - 1));
    frame();
    stream_line(16'd17);

    // copy_start in READY restarts; frame_start during LOAD does nothing
    random_set();
    start_load();
    feed(1'b0, 1'b0);
    start_load();
    pend_valid = 1'b0;
    check("restart_loading", 16'(loading), 16'd1);
    check("restart_no_pending", 16'(swap_pending), 16'd0);
    frame();
    check("frame_in_load", 16'(loading), 16'd1);
    feed(1'b0, 1'b0);
    frame();
    stream_line(16'd33);

    // simultaneous copy_start+frame_start in READY: swap wins
    random_set();
    start_load();
    feed(1'b0, 1'b0);
    copy_start = 1'b1;
    frame();
    copy_start = 1'b0;
    check("sim_loading", 16'(loading), 16'd0);
    check("sim_pending", 16'(swap_pending), 16'd0);
    tick();
    check("sim_not_honoured", 16'(loading), 16'd0);
    stream_line(16'd0);

    // random sets with gapped loads
    for (int s = 0; s < 3; s++) begin
      random_set();
      start_load();
      feed(1'b1, 1'b0);
      frame();
      for (int l = 0; l < 3; l++) stream_line(16'($urandom_range(0, 70)));
    end

    // colour key over rect0
    spec_set();
    set_next[1].c = KEY;
    start_load();
    feed(1'b0, 1'b0);
    frame();
    start_line(16'd6);
    pixel("colour_key", 16'd7, TRANSP ? 16'h1111 : KEY);

    // reset mid-LOAD discards the partial set
    random_set();
    start_load();
    for (int w = 0; w < 100; w++) begin
      mem_valid = 1'b1;
      mem_din   = word_of(w);
      tick();
    end
    mem_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    act_valid = 1'b0; pend_valid = 1'b0;
    check("rst_mid_loading", 16'(loading), 16'd0);
    check("rst_mid_pending", 16'(swap_pending), 16'd0);
    check("rst_mid_color", color, DEF);
    frame();
    check("rst_no_swap", 16'(swap_pending), 16'd0);
    start_line(16'd6);
    pixel("rst_bg", 16'd7, DEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
